// File: rtl/peak_bins_stream.sv
// peak_bins_stream: streaming spectrogram peak picker.
// Buffers FFT magnitude frames (previous / current / next), scans the current
// frame for local maxima against its four time/frequency neighbours, and
// reports the strongest peak found inside each programmable frequency bin.
// Optional build macro: PEAK_THRESH_EN adds a peak_thresh input; a peak then
// only counts when its amplitude is strictly above that threshold.
module peak_bins_stream #(
    parameter int AMPL_W     = 24,
    parameter int OUT_AMPL_W = 8,
    parameter int NFREQS     = 128,
    parameter int FREQ_W     = 7,
    parameter int NBINS      = 6,
    parameter int TIME_W     = 16
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic signed [AMPL_W-1:0]       in_ampl,
    input  logic                           in_last,
    input  logic [NBINS*FREQ_W-1:0]        bin_hi,
`ifdef PEAK_THRESH_EN
    input  logic signed [AMPL_W-1:0]       peak_thresh,
`endif
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [NBINS*OUT_AMPL_W-1:0]    out_ampl,
    output logic [NBINS*FREQ_W-1:0]        out_freq,
    output logic [NBINS-1:0]               out_found,
    output logic [TIME_W-1:0]              counter_out,
    output logic                           frame_err
);

    typedef enum logic [1:0] {
        FILL = 2'd0,
        SCAN = 2'd1,
        EMIT = 2'd2
    } state_t;

    // Beat counter is one bit wider than the frequency index so that
    // over-long frames can be told apart from exactly-full ones.
    localparam int                CNT_W    = FREQ_W + 1;
    localparam logic [CNT_W-1:0]  NFREQS_C = CNT_W'(NFREQS);
    localparam logic [FREQ_W-1:0] LAST_IDX = FREQ_W'(NFREQS - 1);

    state_t state, next_state;

    // Four physical frame buffers: three hold prev/curr/next, the fourth
    // receives the incoming frame so a malformed frame never disturbs them.
    logic signed [AMPL_W-1:0] frame_mem [4][NFREQS];
    logic [1:0] prev_buf, curr_buf, next_buf, wr_buf;
    logic       prev_full, curr_full, next_full;
    logic [CNT_W-1:0] beat_cnt;

    logic beat_fire, beat_write, frame_good, frame_bad, scan_last, emit_load;

    logic [FREQ_W-1:0]       scan_idx;
    logic [FREQ_W-1:0]       idx_m, idx_p;
    logic signed [AMPL_W-1:0] rd_c, rd_m, rd_p, rd_prev, rd_next;

    logic                     pipe_v;
    logic [FREQ_W-1:0]        pipe_idx;
    logic signed [AMPL_W-1:0] pipe_c, pipe_m, pipe_p, pipe_prev, pipe_next;

    logic [NBINS*FREQ_W-1:0] bin_hi_q;
`ifdef PEAK_THRESH_EN
    logic signed [AMPL_W-1:0] thresh_q;
`endif

    logic                     qualifies;
    logic [NBINS-1:0]         bin_sel;

    logic signed [AMPL_W-1:0] win_ampl [NBINS];
    logic [FREQ_W-1:0]        win_freq [NBINS];
    logic [NBINS-1:0]         win_found;

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= FILL;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic: fill until a well-formed frame lands, scan it, then hand off the result.
    always_comb begin
        next_state = state;
        case (state)
            FILL:    if (frame_good) next_state = SCAN;
            SCAN:    if (scan_last)  next_state = EMIT;
            EMIT:    if (emit_load)  next_state = FILL;
            default: next_state = FILL;
        endcase
    end

    // FSM outputs and the handshake strobes derived from them.
    always_comb begin
        in_ready   = (state == FILL);
        beat_fire  = in_valid && in_ready;
        beat_write = beat_fire && (beat_cnt < NFREQS_C);
        frame_good = beat_fire && in_last && ((beat_cnt + 1'b1) == NFREQS_C);
        frame_bad  = beat_fire && in_last && ((beat_cnt + 1'b1) != NFREQS_C);
        scan_last  = (state == SCAN) && (scan_idx == LAST_IDX);
        emit_load  = (state == EMIT) && !pipe_v && (!out_valid || out_ready);
    end

    // Frame storage write port; contents are qualified by the full flags, so no reset is needed.
    always_ff @(posedge clk) begin
        if (beat_write) begin
            frame_mem[wr_buf][beat_cnt[FREQ_W-1:0]] <= in_ampl;
        end
    end

    // Beat counting, slot rotation on a good frame and the malformed-frame pulse.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prev_buf  <= 2'd0;
            curr_buf  <= 2'd1;
            next_buf  <= 2'd2;
            wr_buf    <= 2'd3;
            prev_full <= 1'b0;
            curr_full <= 1'b0;
            next_full <= 1'b0;
            beat_cnt  <= '0;
            frame_err <= 1'b0;
        end else begin
            frame_err <= frame_bad;
            if (frame_good) begin
                prev_buf  <= curr_buf;
                curr_buf  <= next_buf;
                next_buf  <= wr_buf;
                wr_buf    <= prev_buf;
                prev_full <= curr_full;
                curr_full <= next_full;
                next_full <= 1'b1;
                beat_cnt  <= '0;
            end else if (frame_bad) begin
                beat_cnt  <= '0;
            end else if (beat_fire && (beat_cnt <= NFREQS_C)) begin
                beat_cnt  <= beat_cnt + 1'b1;
            end
        end
    end

    // Neighbour fetch for the scan index; empty slots and out-of-range frequencies read as zero.
    always_comb begin
        idx_m   = (scan_idx == '0) ? scan_idx : scan_idx - 1'b1;
        idx_p   = (scan_idx == LAST_IDX) ? scan_idx : scan_idx + 1'b1;
        rd_c    = curr_full ? frame_mem[curr_buf][scan_idx] : '0;
        rd_m    = (curr_full && (scan_idx != '0)) ? frame_mem[curr_buf][idx_m] : '0;
        rd_p    = (curr_full && (scan_idx != LAST_IDX)) ? frame_mem[curr_buf][idx_p] : '0;
        rd_prev = prev_full ? frame_mem[prev_buf][scan_idx] : '0;
        rd_next = next_full ? frame_mem[next_buf][scan_idx] : '0;
    end

    // Scan index, configuration capture on scan entry, and the one-stage read pipeline.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            scan_idx  <= '0;
            bin_hi_q  <= '0;
`ifdef PEAK_THRESH_EN
            thresh_q  <= '0;
`endif
            pipe_v    <= 1'b0;
            pipe_idx  <= '0;
            pipe_c    <= '0;
            pipe_m    <= '0;
            pipe_p    <= '0;
            pipe_prev <= '0;
            pipe_next <= '0;
        end else begin
            scan_idx <= ((state == SCAN) && !scan_last) ? scan_idx + 1'b1 : '0;
            if (frame_good) begin
                bin_hi_q <= bin_hi;
`ifdef PEAK_THRESH_EN
                thresh_q <= peak_thresh;
`endif
            end
            pipe_v    <= (state == SCAN);
            pipe_idx  <= scan_idx;
            pipe_c    <= rd_c;
            pipe_m    <= rd_m;
            pipe_p    <= rd_p;
            pipe_prev <= rd_prev;
            pipe_next <= rd_next;
        end
    end

    // Peak test on the pipelined sample and one-hot selection of the lowest bin that covers it.
    always_comb begin
        logic taken;
        qualifies = (pipe_c >= pipe_m) && (pipe_c >= pipe_p) &&
                    (pipe_c >= pipe_prev) && (pipe_c >= pipe_next);
`ifdef PEAK_THRESH_EN
        qualifies = qualifies && (pipe_c > thresh_q);
`else
        qualifies = qualifies;
`endif
        bin_sel = '0;
        taken   = 1'b0;
        for (int b = 0; b < NBINS; b++) begin
            if (!taken && (pipe_idx <= bin_hi_q[b*FREQ_W +: FREQ_W])) begin
                bin_sel[b] = 1'b1;
                taken      = 1'b1;
            end
        end
    end

    // Per-bin winners: cleared on scan entry; starting from zero with a strict compare
    // means flat or non-positive maxima never register and ties keep the lowest index.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int b = 0; b < NBINS; b++) begin
                win_ampl[b] <= '0;
                win_freq[b] <= '0;
            end
            win_found <= '0;
        end else if (frame_good) begin
            for (int b = 0; b < NBINS; b++) begin
                win_ampl[b] <= '0;
                win_freq[b] <= '0;
            end
            win_found <= '0;
        end else if (pipe_v && qualifies) begin
            for (int b = 0; b < NBINS; b++) begin
                if (bin_sel[b] && (pipe_c > win_ampl[b])) begin
                    win_ampl[b]  <= pipe_c;
                    win_freq[b]  <= pipe_idx;
                    win_found[b] <= 1'b1;
                end
            end
        end
    end

    // Result register: loads once the winners have settled and the previous result is gone.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid   <= 1'b0;
            out_ampl    <= '0;
            out_freq    <= '0;
            out_found   <= '0;
            counter_out <= '0;
        end else if (emit_load) begin
            out_valid   <= 1'b1;
            counter_out <= counter_out + 1'b1;
            out_found   <= win_found;
            for (int b = 0; b < NBINS; b++) begin
                out_ampl[b*OUT_AMPL_W +: OUT_AMPL_W] <= win_ampl[b][AMPL_W-1 -: OUT_AMPL_W];
                out_freq[b*FREQ_W +: FREQ_W]         <= win_freq[b];
            end
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_peak_bins_stream.sv
// tb_peak_bins_stream: directed, table-driven bench for peak_bins_stream
// using a 16-point frame, 4 bins with upper edges {3,7,11,15}.
module tb_peak_bins_stream;

    localparam int AMPL_W     = 16;
    localparam int OUT_AMPL_W = 8;
    localparam int NFREQS     = 16;
    localparam int FREQ_W     = 4;
    localparam int NBINS      = 4;
    localparam int TIME_W     = 16;
    localparam int LATENCY    = NFREQS + 2;

    logic                        clk = 1'b0;
    logic                        reset;
    logic                        in_valid;
    logic                        in_ready;
    logic [AMPL_W-1:0]           in_ampl;
    logic                        in_last;
    logic [NBINS*FREQ_W-1:0]     bin_hi;
    logic                        out_valid;
    logic                        out_ready;
    logic [NBINS*OUT_AMPL_W-1:0] out_ampl;
    logic [NBINS*FREQ_W-1:0]     out_freq;
    logic [NBINS-1:0]            out_found;
    logic [TIME_W-1:0]           counter_out;
    logic                        frame_err;
`ifdef PEAK_THRESH_EN
    logic [AMPL_W-1:0]           peak_thresh;
`endif

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [255:0] frame;
        logic [3:0]   found;
        logic [15:0]  freq;
        logic [31:0]  ampl;
    } vec_t;

    vec_t vecs [7];

    peak_bins_stream #(
        .AMPL_W(AMPL_W), .OUT_AMPL_W(OUT_AMPL_W), .NFREQS(NFREQS),
        .FREQ_W(FREQ_W), .NBINS(NBINS), .TIME_W(TIME_W)
    ) dut (
        .clk(clk),
        .reset(reset),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .in_ampl(in_ampl),
        .in_last(in_last),
        .bin_hi(bin_hi),
`ifdef PEAK_THRESH_EN
        .peak_thresh(peak_thresh),
`endif
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_ampl(out_ampl),
        .out_freq(out_freq),
        .out_found(out_found),
        .counter_out(counter_out),
        .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    function automatic logic [255:0] put(input logic [255:0] f, input int idx, input logic [15:0] v);
        logic [255:0] r;
        r = f;
        r[idx*16 +: 16] = v;
        return r;
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
        end
    endtask

    // Streams len beats; samples past index 15 are zero; in_last on the final beat.
    task automatic applyStimulus(input logic [255:0] frame, input int len);
        for (int n = 0; n < len; n++) begin
            int guard;
            int idx;
            guard    = 0;
            idx      = (n < 16) ? n : 0;
            in_valid = 1'b1;
            in_ampl  = (n < 16) ? frame[idx*16 +: 16] : '0;
            in_last  = (n == len - 1);
            while (!in_ready && guard < 200) begin
                @(posedge clk); #1;
                guard++;
            end
            if (guard >= 200) checkOutput("in_ready_timeout", 64'd0, 64'd1);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic waitResult(output int cyc);
        cyc = 0;
        while (!out_valid && cyc < 60) begin
            @(posedge clk); #1;
            cyc++;
        end
    endtask

    task automatic runFrameCheck(input string tag, input logic [255:0] frame, input logic [3:0] ef,
                                 input logic [15:0] eq, input logic [31:0] ea, input int ecnt);
        int cyc;
        applyStimulus(frame, 16);
        waitResult(cyc);
        checkOutput({tag, ".latency"}, 64'(cyc), 64'(LATENCY));
        checkOutput({tag, ".found"}, 64'(out_found), 64'(ef));
        checkOutput({tag, ".freq"}, 64'(out_freq), 64'(eq));
        checkOutput({tag, ".ampl"}, 64'(out_ampl), 64'(ea));
        checkOutput({tag, ".counter"}, 64'(counter_out), 64'(ecnt));
    endtask

    task automatic expectNoResult(input string tag, input int cycles);
        logic seen;
        seen = 1'b0;
        for (int c = 0; c < cycles; c++) begin
            @(posedge clk); #1;
            if (out_valid) seen = 1'b1;
        end
        checkOutput({tag, ".no_valid"}, 64'(seen), 64'd0);
        checkOutput({tag, ".in_ready"}, 64'(in_ready), 64'd1);
    endtask

    initial begin
        logic [255:0] f;
        int cyc;

        reset     = 1'b1;
        in_valid  = 1'b0;
        in_ampl   = '0;
        in_last   = 1'b0;
        out_ready = 1'b1;
        bin_hi    = 16'hFB73;
`ifdef PEAK_THRESH_EN
        peak_thresh = 16'h8000;
`endif

        // Reset state.
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset.out_valid", 64'(out_valid), 64'd0);
        checkOutput("reset.counter", 64'(counter_out), 64'd0);
        checkOutput("reset.found", 64'(out_found), 64'd0);
        checkOutput("reset.frame_err", 64'(frame_err), 64'd0);
        checkOutput("reset.in_ready", 64'(in_ready), 64'd1);
        reset = 1'b0;
        @(posedge clk); #1;

        // Consecutive frames; each result describes the frame sent one step earlier.
        vecs[0] = '{put('0, 5, 16'h0100), 4'b0000, 16'h0000, 32'h0000_0000};
        vecs[1] = '{'0,                    4'b0010, 16'h0050, 32'h0000_0100};
        f = put('0, 1, 16'h0200);
        f = put(f, 2, 16'h0200);
        vecs[2] = '{f,                     4'b0000, 16'h0000, 32'h0000_0000};
        vecs[3] = '{'0,                    4'b0001, 16'h0001, 32'h0000_0002};
        f = put('0, 0, 16'h0300);
        f = put(f, 3, 16'h0400);
        f = put(f, 4, 16'h0500);
        f = put(f, 9, 16'h1000);
        f = put(f, 10, 16'h0800);
        f = put(f, 15, 16'h7F00);
        vecs[4] = '{f,                     4'b0000, 16'h0000, 32'h0000_0000};
        vecs[5] = '{put('0, 9, 16'h2000),  4'b1011, 16'hF040, 32'h7F00_0503};
        vecs[6] = '{'0,                    4'b0100, 16'h0900, 32'h0020_0000};

        for (int i = 0; i < 7; i++) begin
            runFrameCheck($sformatf("vec%0d", i), vecs[i].frame, vecs[i].found,
                          vecs[i].freq, vecs[i].ampl, i + 1);
        end

        // Short frame: discarded with an error pulse, slots untouched.
        applyStimulus(put('0, 2, 16'h4000), 10);
        checkOutput("short.frame_err", 64'(frame_err), 64'd1);
        @(posedge clk); #1;
        checkOutput("short.frame_err_clear", 64'(frame_err), 64'd0);
        expectNoResult("short", 25);
        runFrameCheck("after_short", put('0, 6, 16'h0600), 4'b0000, 16'h0000, 32'h0000_0000, 8);

        // Over-long frame.
        applyStimulus(put('0, 1, 16'h0700), 20);
        checkOutput("long.frame_err", 64'(frame_err), 64'd1);
        expectNoResult("long", 25);
        checkOutput("long.counter", 64'(counter_out), 64'd8);

        // Backpressure across two frames.
        out_ready = 1'b0;
        applyStimulus('0, 16);
        waitResult(cyc);
        checkOutput("bp1.latency", 64'(cyc), 64'(LATENCY));
        checkOutput("bp1.found", 64'(out_found), 64'h2);
        checkOutput("bp1.freq", 64'(out_freq), 64'h0060);
        checkOutput("bp1.ampl", 64'(out_ampl), 64'h0000_0600);
        checkOutput("bp1.counter", 64'(counter_out), 64'd9);
        applyStimulus('0, 16);
        repeat (25) @(posedge clk);
        #1;
        checkOutput("bp.hold_in_ready", 64'(in_ready), 64'd0);
        checkOutput("bp.hold_valid", 64'(out_valid), 64'd1);
        checkOutput("bp.hold_found", 64'(out_found), 64'h2);
        checkOutput("bp.hold_freq", 64'(out_freq), 64'h0060);
        checkOutput("bp.hold_counter", 64'(counter_out), 64'd9);
        out_ready = 1'b1;
        @(posedge clk); #1;
        checkOutput("bp2.valid", 64'(out_valid), 64'd1);
        checkOutput("bp2.counter", 64'(counter_out), 64'd10);
        checkOutput("bp2.found", 64'(out_found), 64'h0);
        checkOutput("bp2.in_ready", 64'(in_ready), 64'd1);
        @(posedge clk); #1;
        checkOutput("bp2.consumed", 64'(out_valid), 64'd0);

        // Reset in the middle of a scan.
        applyStimulus(put('0, 3, 16'h0100), 16);
        repeat (8) @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        checkOutput("midreset.counter", 64'(counter_out), 64'd0);
        checkOutput("midreset.valid", 64'(out_valid), 64'd0);
        checkOutput("midreset.found", 64'(out_found), 64'd0);
        checkOutput("midreset.frame_err", 64'(frame_err), 64'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;
        checkOutput("midreset.in_ready", 64'(in_ready), 64'd1);
        runFrameCheck("after_reset", put('0, 5, 16'h0100), 4'b0000, 16'h0000, 32'h0000_0000, 1);

`ifdef PEAK_THRESH_EN
        // Threshold above the 0x0100 peak now sitting in the current slot.
        peak_thresh = 16'h0150;
        runFrameCheck("thresh", '0, 4'b0000, 16'h0000, 32'h0000_0000, 2);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/peak_bins_stream.md
Name: peak_bins_stream

Overview:
- Streaming, parametrised successor to the fixed 6-bin spectrogram peak picker.
- Accepts FFT magnitude frames one sample per beat over a valid/ready stream and keeps the previous, current and next frames.
- Scans the current frame for local maxima against its 4 time/frequency neighbours, and reports the strongest peak in each of NBINS runtime-programmable frequency bins.
- Sits between the FFT magnitude stage and the fingerprint hasher.

Parameters:
- AMPL_W, 24, input amplitude width (signed).
- OUT_AMPL_W, 8, output amplitude width; top bits of the winning amplitude.
- NFREQS, 128, samples per frame.
- FREQ_W, 7, frequency index width; ceil(log2(NFREQS)).
- NBINS, 6, number of output bins.
- TIME_W, 16, output frame-counter width.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous active-high reset.
- in_valid  in  1  input beat valid.
- in_ready  out  1  block accepts a beat this cycle.
- in_ampl  in  AMPL_W  signed amplitude; beat n of a frame is frequency index n.
- in_last  in  1  final beat of a frame.
- bin_hi  in  NBINS*FREQ_W  inclusive upper index of each bin; bin b at bits [b*FREQ_W +: FREQ_W].
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts the result.
- out_ampl  out  NBINS*OUT_AMPL_W  per-bin peak amplitude, top OUT_AMPL_W bits.
- out_freq  out  NBINS*FREQ_W  per-bin peak index.
- out_found  out  NBINS  bin contained at least one peak.
- counter_out  out  TIME_W  number of results emitted; value travels with each result.
- frame_err  out  1  one-cycle pulse when a malformed frame is discarded.

Behaviour:
- Reset: all outputs 0; state FILL; write index 0; all three frame slots marked empty. An empty slot reads as 0.
- Reset mid-operation: aborts fill, scan or emit immediately. Partial frames and pending results are lost.
- FILL state:
  - in_ready=1; each accepted beat writes the next slot at the write index, then the index increments.
  - Beats with index >= NFREQS are dropped.
  - On an accepted in_last with count == NFREQS: rotate slots (prev<=curr<=next<=new), mark the new slot full, go to SCAN.
  - On an accepted in_last with count != NFREQS: frame is discarded, no rotation, frame_err pulses next cycle, index returns to 0, state stays FILL.
- SCAN state:
  - in_ready=0; bin_hi is sampled on entry.
  - Exactly NFREQS cycles, index i=0..NFREQS-1.
  - peak(i) = curr[i] >= curr[i-1], curr[i+1], prev[i] and next[i]. Out-of-range frequency neighbours are 0.
  - Bin of i is the lowest b with i <= bin_hi[b]; indices above bin_hi[NBINS-1] are ignored.
  - Per bin, a new peak replaces the stored winner only if strictly greater, so on ties the lowest index wins.
  - bin_hi must be non-decreasing; otherwise results are undefined but the FSM must not hang.
- EMIT state:
  - The result register loads when out_valid=0 or (out_valid & out_ready); then return to FILL.
  - If the previous result is still unaccepted, stay in EMIT with in_ready=0.
- Latency: out_valid rises NFREQS+2 cycles after the edge that accepts in_last, provided output is free.
- out_valid stays high, and data stays stable, until the out_ready handshake completes.
- counter_out is incremented and loaded with each new result; it wraps at 2^TIME_W.
- Bins without a peak: out_found=0, out_freq=0, out_ampl=0.

Optional Feature:
- PEAK_THRESH_EN defined: adds port peak_thresh, in, AMPL_W, signed, sampled on SCAN entry. A peak qualifies only if curr[i] > peak_thresh.
- Undefined: no port; every local maximum qualifies.

Test Plan:
All scenarios use NFREQS=16, NBINS=4, AMPL_W=16, OUT_AMPL_W=8, FREQ_W=4, bin_hi={3,7,11,15}.
- Reset, then one frame with value 0x0100 at index 5 and 0 elsewhere:
  - Result 1 (curr empty): out_found=0000, counter_out=1.
  - After a second all-zero frame, result 2: bin1 found, freq 5, ampl 0x01, all other bins not found.
- Tie: curr has 0x0200 at indices 1 and 2, with prev and next zero -> bin0 freq=1.
- Framing error:
  - in_last on beat 10 -> frame_err pulse, no out_valid, next valid frame processed normally.
  - 20 beats ending with in_last -> frame_err pulse.
- Backpressure: hold out_ready=0 across two frames:
  - in_ready stays 0 in EMIT; first result held stable.
  - After release, second result arrives with counter_out incremented by 1.
- Reset asserted during SCAN cycle 8 -> all outputs 0 within the same cycle. The next frame yields out_found=0000, matching the empty-slot rule.
- PEAK_THRESH_EN with peak_thresh=0x0150 and a peak of 0x0100 -> out_found=0 for that bin.
